mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 41 ++++
 rtl/mem_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg
// Shared sizes and FSM state encodings for the two-port memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2
// Two-way round-robin arbiter; the pointer advances only on an accepted grant.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // High when requester 1 holds the most recent grant.
  logic last_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_q <= gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// Round-robin two-requester memory port with a full-memory clear sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                clr_start,
  output logic                busy,
  output logic                clr_done,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  input  logic [DATA_W-1:0]   mem_out
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [1:0]          rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                busy_q;
  logic                clr_done_q;

  logic [1:0]          w_arb_req;
  logic [1:0]          w_gnt;
  logic [1:0]          w_rd_acc;
  logic                w_sel;

  // A clear request outranks every requester in the cycle it arrives.
  assign w_arb_req = ((state_q == SERVE) && !clr_start) ? req_valid : 2'b00;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (w_arb_req),
    .update (|w_gnt),
    .gnt    (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_sel     = w_gnt[1];
  assign w_rd_acc  = w_gnt & ~req_we;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (state_q == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
    end else begin
      mem_we   = |(w_gnt & req_we);
      mem_addr = w_sel ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
      mem_data = w_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SERVE;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      rsp_valid_q <= w_rd_acc;
      clr_done_q  <= 1'b0;
      if (|w_rd_acc) begin
        rsp_rdata_q <= mem_out;
      end
      case (state_q)
        SERVE: begin
          if (clr_start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          // Counter overflows back to zero on the final write.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_LAST_ADDR) begin
            state_q    <= SERVE;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign clr_done  = clr_done_q;

endmodule

`default_nettype wire
